// File: rtl/x_debounce_pkg.sv
// Shared types and constants for the X input conditioner.
package x_debounce_pkg;

    // Debounce FSM states: two settled levels and two arming phases
    typedef enum logic [1:0] {
        IDLE_LO = 2'd0,
        ARM_HI  = 2'd1,
        IDLE_HI = 2'd2,
        ARM_LO  = 2'd3
    } xdb_state_e;

    localparam int                  GLITCH_W   = 8;
    localparam logic [GLITCH_W-1:0] GLITCH_MAX = 8'd255;

endpackage

// File: rtl/x_debounce_sync_chain.sv
// Multi-flop synchroniser for an asynchronous single-bit input.
// Reusable for any pin input; clears to 0 on asynchronous active-low reset.
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] chain_q;

    // Shift the raw input through the flop chain; bit 0 is the capture flop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/x_debounce.sv
// Debounced, synchronised X level with one-cycle rise/fall strobes.
// Optional feature macro: XDB_GLITCH_CNT_EN adds the 8-bit saturating
// glitch_cnt output counting rejected pulses.
module x_debounce
    import x_debounce_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                raw_in,
    output logic                X,
    output logic                X_rise,
    output logic                X_fall
`ifdef XDB_GLITCH_CNT_EN
    ,
    output logic [GLITCH_W-1:0] glitch_cnt
`endif
);

    // Derived counter width; not meant to be overridden
    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic       s;
    xdb_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic       x_q, x_d;
    logic       rise_q, rise_d;
    logic       fall_q, fall_d;

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (reset_n),
        .d_i   (raw_in),
        .q_o   (s)
    );

    // Next-state logic: count consecutive samples differing from the settled level
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE_LO: begin
                if (s) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d = IDLE_HI;
                        cnt_d   = '0;
                    end else begin
                        state_d = ARM_HI;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            ARM_HI: begin
                if (s) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = IDLE_HI;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
                    state_d = IDLE_LO;
                    cnt_d   = '0;
                end
            end
            IDLE_HI: begin
                if (!s) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d = IDLE_LO;
                        cnt_d   = '0;
                    end else begin
                        state_d = ARM_LO;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            ARM_LO: begin
                if (!s) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = IDLE_LO;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
                    state_d = IDLE_HI;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE_LO;
                cnt_d   = '0;
            end
        endcase
    end

    // The level and strobes are derived from the next state so they register together
    always_comb begin
        x_d    = (state_d == IDLE_HI) || (state_d == ARM_LO);
        rise_d = x_d & ~x_q;
        fall_d = ~x_d & x_q;
    end

    // State, counter, level and strobe registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE_LO;
            cnt_q   <= '0;
            x_q     <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign X      = x_q;
    assign X_rise = rise_q;
    assign X_fall = fall_q;

`ifdef XDB_GLITCH_CNT_EN
    logic                glitch_ev;
    logic [GLITCH_W-1:0] glitch_q;

    function automatic logic [GLITCH_W-1:0] sat_inc(input logic [GLITCH_W-1:0] v);
        return (v == GLITCH_MAX) ? v : v + 1'b1;
    endfunction

    // A glitch is an arming phase abandoned before the flip
    assign glitch_ev = ((state_q == ARM_HI) && !s) || ((state_q == ARM_LO) && s);

    // Saturating count of rejected pulses
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            glitch_q <= '0;
        end else if (glitch_ev) begin
            glitch_q <= sat_inc(glitch_q);
        end
    end

    assign glitch_cnt = glitch_q;
`endif

endmodule

// File: tb/tb_x_debounce.sv
// Directed bench for x_debounce with default parameters.
module tb_x_debounce;

    logic       clk;
    logic       reset_n;
    logic       raw_in;
    logic       X;
    logic       X_rise;
    logic       X_fall;
`ifdef XDB_GLITCH_CNT_EN
    logic [7:0] glitch_cnt;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic raw;
        logic x;
        logic rise;
        logic fall;
        int   g;
    } vec_t;

    vec_t tbl[$];

    x_debounce dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .raw_in     (raw_in),
        .X          (X),
        .X_rise     (X_rise),
        .X_fall     (X_fall)
`ifdef XDB_GLITCH_CNT_EN
        ,
        .glitch_cnt (glitch_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_glitch(input string nm, input int exp);
`ifdef XDB_GLITCH_CNT_EN
        chk(nm, {24'd0, glitch_cnt}, exp);
`endif
    endtask

    // Drive raw_in, pass one rising edge, sample 1 time unit later
    task automatic step(input logic r);
        raw_in = r;
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input logic r, input logic x, input logic ri,
                                input logic fa, input int g);
        vec_t v;
        v.raw = r; v.x = x; v.rise = ri; v.fall = fa; v.g = g;
        tbl.push_back(v);
    endfunction

    initial begin
        int g_exp;
        int x_high;
        int strobe_seen;

        // clean rise: capture at entry 0, flip after entry 5
        for (int i = 0; i < 8; i++) add(1'b1, i >= 5, i == 5, 1'b0, 0);
        // clean fall
        for (int i = 0; i < 8; i++) add(1'b0, i < 5, 1'b0, i == 5, 0);
        // two-cycle pulse: rejected, glitch lands 4 edges after capture
        for (int i = 0; i < 8; i++) add(i < 2, 1'b0, 1'b0, 1'b0, (i >= 4) ? 1 : 0);
        // four-cycle pulse: minimum accepted, then immediate revert and fall
        for (int i = 0; i < 11; i++) add(i < 4, (i >= 5) && (i < 9), i == 5, i == 9, 1);
        // three-cycle pulse: one short of accepted
        for (int i = 0; i < 9; i++) add(i < 3, 1'b0, 1'b0, 1'b0, (i >= 5) ? 2 : 1);

        raw_in  = 1'b0;
        reset_n = 1'b1;
        #1;
        reset_n = 1'b0;
        #1;
        chk("rst_x", X, 0);
        chk("rst_rise", X_rise, 0);
        chk("rst_fall", X_fall, 0);
        chk_glitch("rst_glitch", 0);
        repeat (3) @(posedge clk);
        #3;
        reset_n = 1'b1;

        // reset release with raw_in low
        x_high = 0;
        strobe_seen = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0);
            if (X !== 1'b0) x_high++;
            if (X_rise !== 1'b0 || X_fall !== 1'b0) strobe_seen++;
        end
        chk("idle_x_high_cycles", x_high, 0);
        chk("idle_strobe_cycles", strobe_seen, 0);
        chk_glitch("idle_glitch", 0);

        // table-driven vectors
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].raw);
            chk($sformatf("tbl%0d_x", i), X, tbl[i].x);
            chk($sformatf("tbl%0d_rise", i), X_rise, tbl[i].rise);
            chk($sformatf("tbl%0d_fall", i), X_fall, tbl[i].fall);
            chk_glitch($sformatf("tbl%0d_glitch", i), tbl[i].g);
        end

        // glitch saturation: 300 two-cycle pulses
        g_exp = 2;
        x_high = 0;
        for (int p = 0; p < 300; p++) begin
            step(1'b1); if (X !== 1'b0) x_high++;
            step(1'b1); if (X !== 1'b0) x_high++;
            step(1'b0); if (X !== 1'b0) x_high++;
            step(1'b0); if (X !== 1'b0) x_high++;
            step(1'b0); if (X !== 1'b0) x_high++;
            g_exp = (g_exp < 255) ? g_exp + 1 : 255;
            chk_glitch($sformatf("sat_pulse%0d", p), g_exp);
        end
        chk("sat_x_high_cycles", x_high, 0);
        repeat (5) step(1'b0);
        chk_glitch("sat_hold", 255);

        // reset mid ARM_HI (cnt=2 after four edges)
        repeat (4) step(1'b1);
        chk("arm_x_before_rst", X, 0);
        #3;
        reset_n = 1'b0;
        #1;
        chk("arm_rst_x", X, 0);
        chk("arm_rst_rise", X_rise, 0);
        chk_glitch("arm_rst_glitch", 0);
        #2;
        reset_n = 1'b1;
        for (int j = 0; j < 5; j++) begin
            step(1'b1);
            chk($sformatf("post_rst%0d_x", j), X, 0);
            chk($sformatf("post_rst%0d_rise", j), X_rise, 0);
        end
        step(1'b1);
        chk("post_rst5_x", X, 1);
        chk("post_rst5_rise", X_rise, 1);
        step(1'b1);
        chk("post_rst6_x", X, 1);
        chk("post_rst6_rise", X_rise, 0);
        chk_glitch("post_rst_glitch", 0);

        // asynchronous reset while X=1 and raw_in=1
        #3;
        reset_n = 1'b0;
        #1;
        chk("hi_rst_x", X, 0);
        chk("hi_rst_fall", X_fall, 0);
        #2;
        reset_n = 1'b1;
        step(1'b1);
        chk("hi_rst_exit_x", X, 0);
        chk("hi_rst_exit_fall", X_fall, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/x_debounce.md
# x_debounce

Input conditioner sitting directly upstream of the X-driven sequence FSM: it takes the raw, asynchronous X source (switch or off-chip pin) and produces the clean, single-clock-domain `X` level that the FSM samples. It synchronises the raw input, rejects pulses shorter than a programmable number of cycles, and emits one-cycle edge strobes alongside the clean level. An optional saturating glitch counter supports bring-up diagnostics.

## Interface
- `SYNC_STAGES`, default 2: synchroniser depth; legal values are ≥ 2.
- `DEBOUNCE_CYCLES`, default 4: number of consecutive differing samples required to flip `X`; legal values are ≥ 1.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES+1)`: stability counter width. It is derived and is not overridden.

- `clk`  in  1  sole clock.
- `reset_n`  in  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low.
- `raw_in`  in  1  unsynchronised raw X source.
- `X`  out  1  debounced, synchronised level, fed straight to the FSM's `X` input.
- `X_rise`  out  1  one-cycle strobe, high in the first cycle that `X`=1.
- `X_fall`  out  1  one-cycle strobe, high in the first cycle that `X`=0.
- `glitch_cnt`  out  8  saturating count of rejected pulses. Present only with `XDB_GLITCH_CNT_EN`.

## Operation
- **Synchroniser:** a `SYNC_STAGES`-deep flop chain on `raw_in`. Its last stage `s` is the only signal the FSM sees.
- **State machine** (encoding is free):
  - `IDLE_LO` (`X`=0):
    - `s`=1 → `ARM_HI`, cnt=1.
    - If `DEBOUNCE_CYCLES`=1, go directly to `IDLE_HI`.
  - `ARM_HI` (`X`=0):
    - `s`=1 and cnt==`DEBOUNCE_CYCLES`-1 → `IDLE_HI`, cnt=0.
    - `s`=1 otherwise → cnt+1.
    - `s`=0 → `IDLE_LO`, cnt=0, glitch event.
  - `IDLE_HI` / `ARM_LO`: mirror images of the above with polarity inverted.
- **Output rule:** `X` is registered and equals 1 exactly in `IDLE_HI` and `ARM_LO`. The counter never exceeds `DEBOUNCE_CYCLES`-1.
- **Strobes:** `X_rise`/`X_fall` are registered and asserted in the same cycle as the `X` transition. They are never both high, and each lasts exactly 1 cycle.
- **Glitch event:** any ARM→IDLE return without a flip. Each event increments `glitch_cnt`, which saturates at 255 and has no wrap.

## Timing
- **Reset values:** all synchroniser flops 0, state `IDLE_LO`, cnt 0, `X`=0, `X_rise`=0, `X_fall`=0, `glitch_cnt`=0. Reset takes effect immediately and asynchronously.
- **Reset mid-operation:** asserting `reset_n` in any ARM state discards the partial count. `X` returns to 0 even if `raw_in`=1. No strobe and no glitch event are produced on reset entry or exit.
- **Latency:** `raw_in` settles and is first captured at edge k. `X` changes after edge k + `SYNC_STAGES` + `DEBOUNCE_CYCLES` − 1, provided `raw_in` holds. With defaults this is edge k+5.
- **Minimum accepted pulse:** `DEBOUNCE_CYCLES` cycles as seen at `s`. Anything shorter is rejected and counted as a glitch.
- **No bypass:** `X` is a pure flop output. There is no combinational path from `raw_in` to any output.
- **Polarity change on the flip cycle:** if `s` reverts in the same cycle that the flip is taken, the flip still occurs. The new polarity then starts its own ARM sequence on the next edge.

## Configuration
- **`XDB_GLITCH_CNT_EN` defined:** the `glitch_cnt` port and its 8-bit saturating register exist as specified above.
- **`XDB_GLITCH_CNT_EN` undefined:** the port and the register are absent. All other behaviour and timing are identical.

## Structure
- **Package `x_debounce_pkg`:**
  - the state enum typedef (`IDLE_LO`, `ARM_HI`, `IDLE_HI`, `ARM_LO`);
  - `GLITCH_W` = 8;
  - `GLITCH_MAX` = 255.
- **Sub-module `sync_chain`:** parameterised depth, async active-low reset to 0. It is reused by other pin inputs.
- **`x_debounce` top:** instantiates `sync_chain` and contains the FSM, counter, strobes and optional glitch counter.

## Test plan
- **Reset release:** `raw_in`=0 during and after reset → `X`=0, no strobes, `glitch_cnt`=0 for 20 cycles.
- **Clean rise:** defaults; `raw_in` 0→1 captured at edge k and held → `X`=1 after edge k+5; `X_rise` high for exactly that one cycle; `glitch_cnt` unchanged.
- **Short pulse:** `raw_in` high for 2 cycles then low → `X` stays 0; `glitch_cnt`=1 after the pulse reaches `s`.
- **Clean fall:** from `X`=1, `raw_in` 1→0 held → `X`=0 after edge k+5; `X_fall` high for one cycle.
- **Glitch saturation:** 300 two-cycle pulses → `glitch_cnt` reads 255 and holds; `X` never leaves 0.
- **Reset mid-arm:** assert `reset_n`=0 mid-`ARM_HI` (cnt=2) → `X`, cnt and `glitch_cnt` are 0 immediately, before the next clock edge. After release with `raw_in`=1 held, `X` rises at full latency from the first post-reset edge.
